usb_asp_in_ep_buf: RTL and testbench

IN-endpoint packet buffer between a device-side endpoint client (control endpoint or application) and the USB full-speed packet transmitter.
- Client side: accepts bytes through the in_ep req/grant/free/put/done handshake.
- Host side: on each IN token, answers with one DATA0/DATA1 packet, NAK or STALL.
- Tracks the data toggle, holds the packet until the host ACKs it, and retransmits on timeout.
- Pulses in_ep_acked back to the client.

---
 rtl/usb_asp_in_ep_buf.sv | 135 +++++++++++++
 tb/tb_usb_asp_in_ep_buf.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_asp_in_ep_buf.sv
// rtl/usb_asp_in_ep_buf.sv - USB IN-endpoint packet buffer with data toggle, NAK and retransmit
// Optional feature macro: USB_IN_EP_STALL_EN (endpoint stall flag and STALL handshakes)
module usb_asp_in_ep_buf #(
    parameter int MAX_PKT = 32,
    localparam int CW = $clog2(MAX_PKT + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_ep_req,
    output logic       in_ep_grant,
    output logic       in_ep_data_free,
    input  logic       in_ep_data_put,
    input  logic [7:0] in_ep_data,
    input  logic       in_ep_data_done,
    input  logic       in_ep_stall,
    output logic       in_ep_acked,
    input  logic       in_token,
    input  logic       setup_token,
    output logic       tx_pkt_start,
    output logic [3:0] tx_pid,
    output logic       tx_data_avail,
    input  logic       tx_data_get,
    output logic [7:0] tx_data,
    input  logic       rx_ack,
    input  logic       ack_timeout
);
    localparam int AW = $clog2(MAX_PKT);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PKT);
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [1:0] {FILL, READY, XMIT, WAIT_ACK} state_t;

    state_t        state;
    logic [7:0]    pkt_buf [MAX_PKT];
    logic [CW-1:0] wcount;
    logic [CW-1:0] rptr;
    logic          toggle;
    logic          stall_active;
    logic          wr_en;

`ifdef USB_IN_EP_STALL_EN
    logic stall_flag;
    assign stall_active = stall_flag;

    // SETUP clears the stall even when a stall request lands in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || setup_token)
            stall_flag <= 1'b0;
        else if (in_ep_stall)
            stall_flag <= 1'b1;
    end
`else
    logic unused_stall;
    assign unused_stall = in_ep_stall;
    assign stall_active = 1'b0;
`endif

    assign in_ep_grant     = in_ep_req;
    assign in_ep_data_free = (state == FILL) && (wcount < MAX_CNT);
    assign wr_en           = in_ep_data_put && in_ep_data_free;
    assign tx_data_avail   = (state == XMIT) && (rptr < wcount);
    assign tx_data         = pkt_buf[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en)
            pkt_buf[wcount[AW-1:0]] <= in_ep_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FILL;
            wcount       <= '0;
            rptr         <= '0;
            toggle       <= 1'b0;
            tx_pkt_start <= 1'b0;
            tx_pid       <= 4'b0000;
            in_ep_acked  <= 1'b0;
        end else if (setup_token) begin
            state        <= FILL;
            wcount       <= '0;
            rptr         <= '0;
            toggle       <= 1'b1;
            tx_pkt_start <= 1'b0;
            in_ep_acked  <= 1'b0;
        end else begin
            tx_pkt_start <= 1'b0;
            in_ep_acked  <= 1'b0;
            if (in_token && stall_active) begin
                tx_pkt_start <= 1'b1;
                tx_pid       <= PID_STALL;
            end
            case (state)
                FILL: begin
                    if (wr_en)
                        wcount <= wcount + CW'(1);
                    if (in_token && !stall_active) begin
                        tx_pkt_start <= 1'b1;
                        tx_pid       <= PID_NAK;
                    end
                    if (in_ep_data_done || (wr_en && wcount == MAX_CNT - CW'(1)))
                        state <= READY;
                end
                READY: begin
                    if (in_token && !stall_active) begin
                        tx_pkt_start <= 1'b1;
                        tx_pid       <= toggle ? PID_DATA1 : PID_DATA0;
                        rptr         <= '0;
                        state        <= XMIT;
                    end
                end
                XMIT: begin
                    if (rptr == wcount)
                        state <= WAIT_ACK;
                    else if (tx_data_get)
                        rptr <= rptr + CW'(1);
                end
                WAIT_ACK: begin
                    // Timeout keeps toggle and payload so the retry is byte-identical.
                    if (rx_ack) begin
                        toggle      <= ~toggle;
                        wcount      <= '0;
                        in_ep_acked <= 1'b1;
                        state       <= FILL;
                    end else if (ack_timeout) begin
                        state <= READY;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_asp_in_ep_buf.sv
// tb/tb_usb_asp_in_ep_buf.sv - directed/randomized bench for usb_asp_in_ep_buf against a packet-level model
module tb_usb_asp_in_ep_buf;
    localparam int MAX_PKT = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_ep_req = 1'b0;
    logic       in_ep_grant;
    logic       in_ep_data_free;
    logic       in_ep_data_put = 1'b0;
    logic [7:0] in_ep_data = 8'h00;
    logic       in_ep_data_done = 1'b0;
    logic       in_ep_stall = 1'b0;
    logic       in_ep_acked;
    logic       in_token = 1'b0;
    logic       setup_token = 1'b0;
    logic       tx_pkt_start;
    logic [3:0] tx_pid;
    logic       tx_data_avail;
    logic       tx_data_get = 1'b0;
    logic [7:0] tx_data;
    logic       rx_ack = 1'b0;
    logic       ack_timeout = 1'b0;

    int checks = 0;
    int failures = 0;

    byte unsigned exp_q[$];
    bit           exp_toggle = 1'b0;

    usb_asp_in_ep_buf #(.MAX_PKT(MAX_PKT)) dut (
        .clk(clk), .reset(reset),
        .in_ep_req(in_ep_req), .in_ep_grant(in_ep_grant),
        .in_ep_data_free(in_ep_data_free), .in_ep_data_put(in_ep_data_put),
        .in_ep_data(in_ep_data), .in_ep_data_done(in_ep_data_done),
        .in_ep_stall(in_ep_stall), .in_ep_acked(in_ep_acked),
        .in_token(in_token), .setup_token(setup_token),
        .tx_pkt_start(tx_pkt_start), .tx_pid(tx_pid),
        .tx_data_avail(tx_data_avail), .tx_data_get(tx_data_get),
        .tx_data(tx_data), .rx_ack(rx_ack), .ack_timeout(ack_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] data_pid();
        return exp_toggle ? 4'b1011 : 4'b0011;
    endfunction

    task automatic put_byte(input logic [7:0] d);
        chk("data_free", in_ep_data_free, exp_q.size() < MAX_PKT);
        in_ep_data_put = 1'b1;
        in_ep_data     = d;
        tick();
        in_ep_data_put = 1'b0;
        if (exp_q.size() < MAX_PKT)
            exp_q.push_back(d);
    endtask

    task automatic done_pkt();
        in_ep_data_done = 1'b1;
        tick();
        in_ep_data_done = 1'b0;
    endtask

    task automatic in_tok(input string tag, input logic [3:0] pid);
        in_token = 1'b1;
        tick();
        in_token = 1'b0;
        chk({tag, "_start"}, tx_pkt_start, 1'b1);
        chk({tag, "_pid"}, tx_pid, pid);
    endtask

    task automatic stream_pkt();
        for (int i = 0; i < exp_q.size(); i++) begin
            chk("tx_avail", tx_data_avail, 1'b1);
            chk("tx_data", tx_data, exp_q[i]);
            tx_data_get = 1'b1;
            tick();
            tx_data_get = 1'b0;
        end
        chk("tx_avail_end", tx_data_avail, 1'b0);
        tick();
        chk("tx_avail_wait", tx_data_avail, 1'b0);
    endtask

    task automatic ack_pkt(input bit with_timeout);
        rx_ack      = 1'b1;
        ack_timeout = with_timeout;
        tick();
        rx_ack      = 1'b0;
        ack_timeout = 1'b0;
        chk("acked_pulse", in_ep_acked, 1'b1);
        exp_toggle = ~exp_toggle;
        exp_q.delete();
        tick();
        chk("acked_clear", in_ep_acked, 1'b0);
        chk("free_after_ack", in_ep_data_free, 1'b1);
    endtask

    task automatic timeout_pkt();
        ack_timeout = 1'b1;
        tick();
        ack_timeout = 1'b0;
        chk("timeout_no_ack", in_ep_acked, 1'b0);
        chk("timeout_no_free", in_ep_data_free, 1'b0);
    endtask

    task automatic setup_pulse();
        setup_token = 1'b1;
        tick();
        setup_token = 1'b0;
        exp_toggle = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        int len;
        tick();
        tick();
        chk("rst_free", in_ep_data_free, 1'b1);
        chk("rst_avail", tx_data_avail, 1'b0);
        chk("rst_start", tx_pkt_start, 1'b0);
        chk("rst_pid", tx_pid, 4'b0000);
        chk("rst_acked", in_ep_acked, 1'b0);
        reset = 1'b0;
        in_ep_req = 1'b1;
        #1;
        chk("grant_hi", in_ep_grant, 1'b1);
        in_ep_req = 1'b0;
        #1;
        chk("grant_lo", in_ep_grant, 1'b0);

        // SETUP forces DATA1, then an 18-byte ascending packet
        setup_pulse();
        for (int i = 0; i < 18; i++)
            put_byte(8'(i));
        done_pkt();
        in_tok("in18", data_pid());
        stream_pkt();
        ack_pkt(1'b0);

        // NAK while filling, then the 5 buffered bytes go out
        for (int i = 0; i < 5; i++)
            put_byte(8'($urandom));
        in_tok("nak_fill", 4'b1010);
        chk("fill_after_nak", in_ep_data_free, 1'b1);
        done_pkt();
        in_tok("in5", data_pid());
        stream_pkt();
        ack_pkt(1'b0);

        // Auto-complete at MAX_PKT, overflow put dropped, timeout retransmit
        for (int i = 0; i < MAX_PKT + 1; i++)
            put_byte(8'($urandom));
        chk("full_free", in_ep_data_free, 1'b0);
        in_tok("in_full", data_pid());
        stream_pkt();
        timeout_pkt();
        in_tok("in_retry", data_pid());
        stream_pkt();
        ack_pkt(1'b0);

        // Zero-length packet
        done_pkt();
        in_tok("in_zlp", data_pid());
        stream_pkt();
        ack_pkt(1'b0);

        // rx_ack wins over a same-cycle timeout
        len = $urandom_range(1, 10);
        for (int i = 0; i < len; i++)
            put_byte(8'($urandom));
        done_pkt();
        in_tok("in_both", data_pid());
        stream_pkt();
        ack_pkt(1'b1);

        for (int it = 0; it < 5; it++) begin
            len = $urandom_range(0, MAX_PKT);
            for (int i = 0; i < len; i++)
                put_byte(8'($urandom));
            if (len < MAX_PKT)
                done_pkt();
            in_tok("in_rand", data_pid());
            stream_pkt();
            if ($urandom_range(0, 1) == 1) begin
                timeout_pkt();
                in_tok("in_rand_retry", data_pid());
                stream_pkt();
            end
            ack_pkt(1'b0);
        end

        // Stall handling
        in_ep_stall = 1'b1;
        tick();
        in_ep_stall = 1'b0;
`ifdef USB_IN_EP_STALL_EN
        in_tok("in_stall", 4'b1110);
`else
        in_tok("in_stall", 4'b1010);
`endif
        chk("stall_keeps_fill", in_ep_data_free, 1'b1);
        setup_pulse();
        in_tok("in_after_setup", 4'b1010);
        in_ep_stall = 1'b1;
        setup_token = 1'b1;
        tick();
        in_ep_stall = 1'b0;
        setup_token = 1'b0;
        in_tok("in_stall_vs_setup", 4'b1010);

        // Reset in the middle of a transmission
        for (int i = 0; i < 6; i++)
            put_byte(8'($urandom));
        done_pkt();
        in_tok("in_pre_reset", data_pid());
        for (int i = 0; i < 2; i++) begin
            chk("pre_reset_data", tx_data, exp_q[i]);
            tx_data_get = 1'b1;
            tick();
            tx_data_get = 1'b0;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_toggle = 1'b0;
        exp_q.delete();
        chk("mid_rst_avail", tx_data_avail, 1'b0);
        chk("mid_rst_free", in_ep_data_free, 1'b1);
        chk("mid_rst_pid", tx_pid, 4'b0000);

        for (int i = 0; i < 3; i++)
            put_byte(8'($urandom));
        done_pkt();
        in_tok("in_post_reset", data_pid());
        stream_pkt();
        ack_pkt(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
